// File: rtl/pc_gen_unit_if.sv
// Fetch-side handshake between the PC generator and instruction memory.
// The master drives the PC request; the slave returns Fetch_Ready.
interface pc_gen_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            Fetch_Valid;
    logic            Fetch_Ready;
    logic [XLEN-1:0] Pc_Out;
    logic [XLEN-1:0] Pc_Add_Out;

    modport master (
        output Fetch_Valid,
        output Pc_Out,
        output Pc_Add_Out,
        input  Fetch_Ready
    );

    modport slave (
        input  Fetch_Valid,
        input  Pc_Out,
        input  Pc_Add_Out,
        output Fetch_Ready
    );
endinterface

// File: rtl/pc_gen_unit.sv
// Fetch-stage program-counter generator with trap/branch redirects, stall and
// misalignment checks. Optional compressed-instruction support via `RVC_EN.
module pc_gen_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h100),
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Stall,
    input  logic             Br_Taken,
    input  logic [XLEN-1:0]  Br_Target,
    input  logic             Trap_Req,
    input  logic [XLEN-1:0]  Trap_Target,
    input  logic             Is_Compressed,
    pc_gen_unit_if.master    fetch_if,
    output logic             Misalign_Err,
    output logic [CNT_W-1:0] Fetch_Count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

`ifdef RVC_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(1);
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  w_pc_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [XLEN-1:0]  w_step;
    logic [XLEN-1:0]  w_pc_add;
    logic             w_accept;
    logic             w_br_misaligned;

    // Instruction step size
`ifdef RVC_EN
    assign w_step = Is_Compressed ? XLEN'(2) : XLEN'(4);
`else
    logic w_unused_is_compressed;
    assign w_unused_is_compressed = Is_Compressed;
    assign w_step = XLEN'(4);
`endif

    assign w_pc_add        = r_pc + w_step;
    assign w_accept        = r_valid & fetch_if.Fetch_Ready & ~Stall;
    assign w_br_misaligned = |(Br_Target & ALIGN_MASK);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_VEC;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, PC selection and counter update
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;

        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  if (Stall)  w_state_nxt = ST_HOLD;
            ST_HOLD: if (!Stall) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase

        // BOOT ignores every request; otherwise trap > branch > accept > hold
        if (r_state != ST_BOOT) begin
            if (Trap_Req) begin
                w_pc_nxt = Trap_Target & ~ALIGN_MASK;
            end else if (Br_Taken) begin
                if (w_br_misaligned) begin
                    w_pc_nxt  = TRAP_VEC;
                    w_err_nxt = 1'b1;
                end else begin
                    w_pc_nxt = Br_Target;
                end
            end else if (w_accept) begin
                w_pc_nxt = w_pc_add;
            end
        end

        // A consumed request counts even when a redirect overrides the PC
        if (w_accept) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end

        w_valid_nxt = (w_state_nxt == ST_RUN);
    end

    assign fetch_if.Fetch_Valid = r_valid;
    assign fetch_if.Pc_Out      = r_pc;
    assign fetch_if.Pc_Add_Out  = w_pc_add;
    assign Misalign_Err         = r_err;
    assign Fetch_Count          = r_cnt;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: vector table through a scoreboard
// queue, plus hand sequences for counter wrap and mid-request reset.
module tb_pc_gen_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             stall;
    logic             br_taken;
    logic [XLEN-1:0]  br_target;
    logic             trap_req;
    logic [XLEN-1:0]  trap_target;
    logic             is_compressed;
    logic             misalign_err;
    logic [CNT_W-1:0] fetch_count;

    pc_gen_unit_if #(.XLEN(XLEN)) fetch_if ();

    pc_gen_unit #(
        .XLEN      (XLEN),
        .RESET_VEC (32'h0),
        .TRAP_VEC  (32'h100),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Stall         (stall),
        .Br_Taken      (br_taken),
        .Br_Target     (br_target),
        .Trap_Req      (trap_req),
        .Trap_Target   (trap_target),
        .Is_Compressed (is_compressed),
        .fetch_if      (fetch_if.master),
        .Misalign_Err  (misalign_err),
        .Fetch_Count   (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic             stall;
        logic             ready;
        logic             br;
        logic [XLEN-1:0]  br_tgt;
        logic             trap;
        logic [XLEN-1:0]  trap_tgt;
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    typedef struct {
        string            name;
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input string name, input logic st, input logic rdy,
                                input logic br, input logic [XLEN-1:0] bt,
                                input logic tr, input logic [XLEN-1:0] tt,
                                input logic v, input logic [XLEN-1:0] pc,
                                input logic e, input logic [CNT_W-1:0] c);
        vec_t r;
        r.name = name; r.stall = st; r.ready = rdy; r.br = br; r.br_tgt = bt;
        r.trap = tr; r.trap_tgt = tt; r.valid = v; r.pc = pc; r.err = e; r.cnt = c;
        return r;
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Compare DUT outputs against the oldest scoreboard entry
    task automatic check_sb();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = sb_q.pop_front();
            check({e.name, ".valid"}, XLEN'(fetch_if.Fetch_Valid), XLEN'(e.valid));
            check({e.name, ".pc"},    fetch_if.Pc_Out,             e.pc);
            check({e.name, ".add"},   fetch_if.Pc_Add_Out,         e.pc + XLEN'(4));
            check({e.name, ".err"},   XLEN'(misalign_err),         XLEN'(e.err));
            check({e.name, ".cnt"},   XLEN'(fetch_count),          XLEN'(e.cnt));
        end
    endtask

    // Called in the low clock phase: drive, clock once, compare, return low
    task automatic run_vec(input vec_t v);
        exp_t e;
        stall = v.stall; fetch_if.Fetch_Ready = v.ready;
        br_taken = v.br; br_target = v.br_tgt;
        trap_req = v.trap; trap_target = v.trap_tgt;
        e.name = v.name; e.valid = v.valid; e.pc = v.pc; e.err = v.err; e.cnt = v.cnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_sb();
        @(negedge clk);
    endtask

    task automatic idle_inputs(input logic rdy);
        stall = 1'b0; br_taken = 1'b0; trap_req = 1'b0;
        br_target = '0; trap_target = '0; fetch_if.Fetch_Ready = rdy;
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        is_compressed = 1'b0;
        idle_inputs(1'b1);
        rst = 1'b0;
        #1 rst = 1'b1;

        //        name        st rdy br target         tr trap_tgt       v  pc              e  cnt
        vecs.push_back(mk("boot",     0, 1, 0, 32'h0,        0, 32'h0,   1, 32'h0,        0, 16'd0));
        vecs.push_back(mk("seq4",     0, 1, 0, 32'h0,        0, 32'h0,   1, 32'h4,        0, 16'd1));
        vecs.push_back(mk("seq8",     0, 1, 0, 32'h0,        0, 32'h0,   1, 32'h8,        0, 16'd2));
        vecs.push_back(mk("wait1",    0, 0, 0, 32'h0,        0, 32'h0,   1, 32'h8,        0, 16'd2));
        vecs.push_back(mk("wait2",    0, 0, 0, 32'h0,        0, 32'h0,   1, 32'h8,        0, 16'd2));
        vecs.push_back(mk("wait3",    0, 0, 0, 32'h0,        0, 32'h0,   1, 32'h8,        0, 16'd2));
        vecs.push_back(mk("seqC",     0, 1, 0, 32'h0,        0, 32'h0,   1, 32'hC,        0, 16'd3));
        vecs.push_back(mk("seq10",    0, 1, 0, 32'h0,        0, 32'h0,   1, 32'h10,       0, 16'd4));
        vecs.push_back(mk("stall1",   1, 1, 0, 32'h0,        0, 32'h0,   0, 32'h10,       0, 16'd4));
        vecs.push_back(mk("stall_br", 1, 1, 1, 32'h80,       0, 32'h0,   0, 32'h80,       0, 16'd4));
        vecs.push_back(mk("unstall",  0, 1, 0, 32'h0,        0, 32'h0,   1, 32'h80,       0, 16'd4));
        vecs.push_back(mk("seq84",    0, 1, 0, 32'h0,        0, 32'h0,   1, 32'h84,       0, 16'd5));
        vecs.push_back(mk("trap_br",  0, 1, 1, 32'h40,       1, 32'h203, 1, 32'h200,      0, 16'd6));
        vecs.push_back(mk("misalign", 0, 0, 1, 32'h42,       0, 32'h0,   1, 32'h100,      1, 16'd6));
        vecs.push_back(mk("err_drop", 0, 0, 0, 32'h0,        0, 32'h0,   1, 32'h100,      0, 16'd6));
        vecs.push_back(mk("br_acc",   0, 1, 1, 32'h1000,     0, 32'h0,   1, 32'h1000,     0, 16'd7));
        vecs.push_back(mk("br_top",   0, 0, 1, 32'hFFFF_FFFC,0, 32'h0,   1, 32'hFFFF_FFFC,0, 16'd7));
        vecs.push_back(mk("pc_wrap",  0, 1, 0, 32'h0,        0, 32'h0,   1, 32'h0,        0, 16'd8));

        repeat (2) @(posedge clk);
        #1;
        check("rst.pc",    fetch_if.Pc_Out,             32'h0);
        check("rst.valid", XLEN'(fetch_if.Fetch_Valid), 32'h0);
        check("rst.err",   XLEN'(misalign_err),         32'h0);
        check("rst.cnt",   XLEN'(fetch_count),          32'h0);

        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) run_vec(vecs[i]);

        // Counter wrap: 65527 more accepts take the count to all-ones
        idle_inputs(1'b1);
        for (int i = 0; i < 65527; i++) @(negedge clk);
        check("cnt_max", XLEN'(fetch_count), 32'h0000_FFFF);
        run_vec(mk("cnt_wrap", 0, 1, 0, 32'h0, 0, 32'h0, 1, XLEN'(65528 * 4), 0, 16'd0));

        // Reset in the middle of an un-accepted request, away from any edge
        idle_inputs(1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("mid_rst.pc",    fetch_if.Pc_Out,             32'h0);
        check("mid_rst.valid", XLEN'(fetch_if.Fetch_Valid), 32'h0);
        check("mid_rst.cnt",   XLEN'(fetch_count),          32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk("reboot",    0, 1, 0, 32'h0, 0, 32'h0,   1, 32'h0,   0, 16'd0));
        run_vec(mk("reboot4",   0, 1, 0, 32'h0, 0, 32'h0,   1, 32'h4,   0, 16'd1));
        run_vec(mk("hold",      1, 1, 0, 32'h0, 0, 32'h0,   0, 32'h4,   0, 16'd1));
        run_vec(mk("hold_trap", 1, 1, 0, 32'h0, 1, 32'h302, 0, 32'h300, 0, 16'd1));
        run_vec(mk("resume",    0, 1, 0, 32'h0, 0, 32'h0,   1, 32'h300, 0, 16'd1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
